// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver.
// The serial line is synchronized, decoded by a small FSM that samples at
// mid-bit, and completed bytes are queued in a circular FIFO. The core reads
// bytes and status over a valid/we bus. rx_irq is high while bytes are waiting.
module uart_rx_ip #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        rxd,
    output logic        rx_irq
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_FW       = PTR_W + 1;

    // Half-bit point for start validation, full-bit point for data/stop.
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer and receiver state
    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;

    // FIFO state
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_FW-1:0] r_count;

    // Sticky flags and bus-visible registers
    logic              r_overrun;
    logic              r_frame_err;
    logic              r_irq;
    logic [31:0]       r_rdata;

    logic              w_rx_s;
    logic              w_stop_sample;
    logic              w_push;
    logic              w_frame_evt;
    logic              w_rd;
    logic              w_wr;
    logic [1:0]        w_sel;
    logic              w_pop;
    logic              w_full;
    logic              w_not_empty;
    logic              w_busy;
    logic              w_push_ok;
    logic              w_overrun_evt;
    logic              w_clr_ovr;
    logic              w_clr_ferr;
    logic [CNT_FW-1:0] w_count_next;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_rx_s = r_sync2;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame decoder: validate start at half-bit, then sample each bit at mid-bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A line already back high was only a glitch.
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // Hold here until the line idles so a stuck-low line
                    // cannot generate back-to-back bogus frames.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_stop_sample = (r_state == S_STOP) && (r_cnt == CNT_LAST);
    assign w_push        = w_stop_sample && w_rx_s;
    assign w_frame_evt   = w_stop_sample && !w_rx_s;

    assign w_rd          = bus_valid && !bus_we;
    assign w_wr          = bus_valid && bus_we;
    assign w_sel         = bus_addr[3:2];
    assign w_not_empty   = (r_count != '0);
    assign w_full        = (r_count == FIFO_FULL);
    assign w_busy        = (r_state != S_IDLE);
    assign w_pop         = w_rd && (w_sel == 2'd0) && w_not_empty;
    // Full is judged on the pre-pop count: a same-cycle pop does not make room.
    assign w_push_ok     = w_push && !w_full;
    assign w_overrun_evt = w_push && w_full;
    assign w_clr_ovr     = w_wr && (w_sel == 2'd1) && bus_wdata[1];
    assign w_clr_ferr    = w_wr && (w_sel == 2'd1) && bus_wdata[2];

    assign w_status = {20'b0, 4'(r_count), 3'b0, w_full, w_busy,
                       r_frame_err, r_overrun, w_not_empty};

    // Only address bits [3:2] and status clear bits [2:1] are meaningful.
    assign w_unused = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:3], bus_wdata[0]};

    // Next FIFO occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_next = r_count + CNT_FW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_next = r_count - CNT_FW'(1);
        end
    end

    // FIFO storage write port (no reset so it can map onto RAM).
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and count; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Sticky error flags; a set event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_overrun_evt || (r_overrun && !w_clr_ovr);
            r_frame_err <= w_frame_evt || (r_frame_err && !w_clr_ferr);
        end
    end

    // Interrupt tracks the occupancy that becomes visible after this edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_next != '0);
        end
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            case (w_sel)
                2'd0:    r_rdata <= w_not_empty ? {23'b0, 1'b1, r_mem[r_rd_ptr]} : 32'd0;
                2'd1:    r_rdata <= w_status;
                default: r_rdata <= 32'd0;
            endcase
        end
    end

    assign bus_rdata = r_rdata;
    assign rx_irq    = r_irq;

endmodule

// File: doc/uart_rx_ip.md
# uart_rx_ip

Memory-mapped UART receiver: the receive-side counterpart of the SoC's TX-only UART emitter. It samples the `RXD` pin as 8N1 frames, buffers received bytes in a small FIFO, and exposes them to the RISC-V core over the same simple valid/we bus as the GPIO block. It raises a level interrupt while data is pending.

## Interface
- `CLK_FREQ_HZ`, 12_000_000, system clock frequency.
- `BAUD_RATE`, 9600, line rate. `CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE` (integer division), must be ≥ 4.
- `FIFO_DEPTH`, 4, receive FIFO entries. Power of two, 2..8.

Ports:
- `clk` input 1: system clock; the only clock.
- `resetn` input 1: asynchronous, active-low reset.
- `bus_valid` input 1: bus access this cycle.
- `bus_we` input 1: 1 = write, 0 = read.
- `bus_addr` input 32: byte address; only `[3:2]` decoded.
- `bus_wdata` input 32: write data.
- `bus_rdata` output 32: registered read data.
- `rxd` input 1: asynchronous serial line, idle high.
- `rx_irq` output 1: high while the FIFO is non-empty.

## Operation
- Register map, selected by `bus_addr[3:2]`:
  - 0 DATA (RO): `{23'b0, valid, byte}`. A read with FIFO non-empty returns `valid`=1 and the head byte, then pops. A read with FIFO empty returns 0 and changes nothing.
  - 1 STATUS: bit0 not_empty, bit1 overrun (sticky), bit2 frame_err (sticky), bit3 busy (FSM not IDLE), bit4 full, bits[11:8] count, other bits 0. A write of 1 to bit1 or bit2 clears that flag. Other written bits are ignored.
  - 2, 3: read 0. Writes to any address other than STATUS are ignored.
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. Only the synchronized `rx_s` is used downstream.
- FSM states: IDLE, START, DATA, STOP, BREAK. One baud counter and one 3-bit bit index.
  - IDLE: when `rx_s`=0, clear the counter and go to START.
  - START: count to `CLKS_PER_BIT/2 - 1`. If `rx_s`=0 at that point, go to DATA with the counter cleared. Otherwise the low pulse was a glitch; return to IDLE with nothing recorded.
  - DATA: every `CLKS_PER_BIT` clocks, sample `rx_s` into a shift register, LSB first. After bit 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` clocks, sample.
    - `rx_s`=1: push the byte. If the FIFO is full, drop the byte and set overrun. Go to IDLE.
    - `rx_s`=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- FIFO: circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`, plus a count register.
  - Push and pop in the same cycle with count ≥ 1: both occur and the count is unchanged.
  - Push and pop in the same cycle with count = 0: the pop sees empty (returns 0) and the push proceeds.
  - Push while full, even if a pop happens the same cycle: the byte is dropped and overrun is set. The full check uses the pre-pop count.
- Simultaneous events on the sticky flags: a set event in the same cycle as a clear write leaves the flag set.
- `rx_irq` = not_empty, driven from a register.

## Timing
- Reset values: `bus_rdata`=0, `rx_irq`=0, FIFO empty, pointers 0, overrun/frame_err 0, FSM in IDLE, synchronizer flops 1.
- Asserting `resetn` mid-frame aborts the frame immediately. No partial byte is pushed.
- Read latency is 1 cycle: `bus_rdata` updates on the clock edge where `bus_valid & !bus_we` is sampled, and holds until the next read.
- The pop and the STATUS clear take effect on that same edge. The next access sees the new state.
- Start detection occurs 2 clocks after the `rxd` falling edge (synchronizer delay).
- Push happens at the stop-bit sample, about 9.5 bit times after start detection. not_empty, count and `rx_irq` become visible 1 cycle after the push edge.
- No wait states. The block accepts an access every cycle.

## Test plan
All scenarios use `CLK_FREQ_HZ`=16, `BAUD_RATE`=1, so `CLKS_PER_BIT`=16, and `FIFO_DEPTH`=4.

- Reset with `rxd`=1 → STATUS read returns 0x00000000 and `rx_irq`=0. Asserting `resetn` low mid-byte leaves the FIFO empty.
- Frame 0xA5 sent → `rx_irq`=1 and STATUS = 0x00000101. DATA read returns 0x000001A5. STATUS then reads 0x00000000, `rx_irq`=0, and a second DATA read returns 0.
- Bytes 0x01..0x05 sent with no reads → STATUS = 0x00000413 (count 4, full, overrun, not_empty). DATA reads return 0x101, 0x102, 0x103, 0x104, then 0. Writing STATUS 0x2 clears overrun.
- Frame 0x3C with stop bit 0, `rxd` held low for 3 more bit times, then 0x55 sent → frame_err set with FIFO empty before 0x55 arrives. 0x55 is received as 0x155, and BREAK causes no spurious frame.
- `rxd` low for 4 clocks (< half bit) → no byte pushed. busy returns to 0 and count stays 0.
- DATA read issued on the stop-sample push edge with count=1 → read returns the old head byte and count stays 1. The next read returns the new byte.
